// File: rtl/scalar_wb_sequencer.sv
// scalar_wb_sequencer
// Write-side front end for the scalar register file. Merges single-cycle ALU
// results with queued load-return data onto the single write port. It also
// keeps a busy scoreboard of registers with outstanding loads, so the issue
// stage can see read-after-load hazards.

module scalar_wb_sequencer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int NREG       = 16,
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_dst,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic              hazard,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_dst,
    output logic [DATA_W-1:0] wr_data
);

    localparam int CNT_W = $clog2(LQ_DEPTH + 1);
    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] LQ_FULL   = CNT_W'(LQ_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(LQ_DEPTH - 1);
    localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);

    logic [ADDR_W-1:0] lq_dst  [LQ_DEPTH];
    logic [DATA_W-1:0] lq_data [LQ_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve;
    logic [NREG-1:0]   busy;

    logic lq_empty;
    logic force_ld;
    logic alu_win;
    logic ld_pop;
    logic ld_push;

    // Arbitration: the ALU normally wins, unless the load queue has been starved too long
    always_comb begin
        lq_empty  = (count == '0);
        force_ld  = (starve == STV_LIMIT) && !lq_empty;
        alu_ready = !force_ld;
        alu_win   = alu_valid && alu_ready;
        ld_pop    = !alu_win && !lq_empty;
        ld_ready  = (count < LQ_FULL);
        ld_push   = ld_valid && ld_ready;
        hazard    = busy[rd_addr_1] | busy[rd_addr_2];
    end

    // Queue payload storage; only the pointers need a reset
    always_ff @(posedge clk) begin
        if (ld_push) begin
            lq_dst[wr_ptr]  <= ld_dst;
            lq_data[wr_ptr] <= ld_data;
        end
    end

    // Queue pointers and occupancy; a pop only ever sees entries present at cycle start
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (ld_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (ld_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({ld_push, ld_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starvation counter: counts ALU wins over a waiting load, saturating at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= '0;
        end else if (lq_empty || ld_pop) begin
            starve <= '0;
        end else if (alu_win && (starve != STV_LIMIT)) begin
            starve <= starve + 1'b1;
        end
    end

    // Registered write port; when nothing wins, address and data hold their last values
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_dst  <= '0;
            wr_data <= '0;
        end else if (alu_win) begin
            wr_en   <= 1'b1;
            wr_dst  <= alu_dst;
            wr_data <= alu_data;
        end else if (ld_pop) begin
            wr_en   <= 1'b1;
            wr_dst  <= lq_dst[rd_ptr];
            wr_data <= lq_data[rd_ptr];
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Busy scoreboard: a new issue beats a same-cycle retire of the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (ld_pop) begin
                busy[lq_dst[rd_ptr]] <= 1'b0;
            end
            if (issue_en) begin
                busy[issue_dst] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scalar_wb_sequencer.sv
// tb_scalar_wb_sequencer
// Directed scenarios for the write-back sequencer. Expected register-file
// writes are queued as stimulus is issued. A negedge monitor pops the queue
// and compares it against every write the DUT presents.

module tb_scalar_wb_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_dst;
    logic [DATA_W-1:0] ld_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_dst;
    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic              hazard;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_dst;
    logic [DATA_W-1:0] wr_data;

    int n_compared = 0;
    int n_failed   = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q [$];

    // Per-cycle expectations for the queue-full / starvation sequence
    int exp_alu_rdy [11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int exp_ld_rdy  [11] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};

    scalar_wb_sequencer #(
        .DATA_W(16), .ADDR_W(4), .NREG(16), .LQ_DEPTH(2), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_dst(alu_dst), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_dst(ld_dst), .ld_data(ld_data),
        .issue_en(issue_en), .issue_dst(issue_dst),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .hazard(hazard),
        .wr_en(wr_en), .wr_dst(wr_dst), .wr_data(wr_data)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(
        input logic              a_v,  input logic [ADDR_W-1:0] a_d, input logic [DATA_W-1:0] a_x,
        input logic              l_v,  input logic [ADDR_W-1:0] l_d, input logic [DATA_W-1:0] l_x,
        input logic              i_en, input logic [ADDR_W-1:0] i_d,
        input logic [ADDR_W-1:0] ra1,  input logic [ADDR_W-1:0] ra2
    );
        alu_valid = a_v;  alu_dst = a_d;   alu_data = a_x;
        ld_valid  = l_v;  ld_dst  = l_d;   ld_data  = l_x;
        issue_en  = i_en; issue_dst = i_d;
        rd_addr_1 = ra1;  rd_addr_2 = ra2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented write must match the oldest expected write
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_compared++;
            if (exp_q.size() == 0) begin
                n_failed++;
                $display("[TB] FAIL unexpected_write: got dst=%0h data=%0h expected no write", wr_dst, wr_data);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                if ({wr_dst, wr_data} !== e) begin
                    n_failed++;
                    $display("[TB] FAIL write_order: got dst=%0h data=%0h expected dst=%0h data=%0h",
                             wr_dst, wr_data, e[DATA_W +: ADDR_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset then idle
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        rst = 1'b0;
        #1;
        checkOutput("reset_wr_en",   wr_en,    0);
        checkOutput("reset_wr_dst",  wr_dst,   0);
        checkOutput("reset_wr_data", wr_data,  0);
        checkOutput("reset_ld_rdy",  ld_ready, 1);
        checkOutput("reset_hazard",  hazard,   0);
        checkOutput("reset_alu_rdy", alu_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("idle_wr_en", wr_en, 0);
        end

        // ALU only: write at N+1, gone at N+2
        applyStimulus(1, 4'd3, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("alu_ready", alu_ready, 1);
        exp_q.push_back({4'd3, 16'hBEEF});
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("alu_wr_en",   wr_en,   1);
        checkOutput("alu_wr_dst",  wr_dst,  3);
        checkOutput("alu_wr_data", wr_data, 16'hBEEF);
        step();
        #1;
        checkOutput("alu_wr_en_off", wr_en, 0);

        // Load with scoreboard: issue sets busy, pop clears it with the write at N+2
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd5, 0, 0);
        step();
        applyStimulus(0, 0, 0, 1, 4'd5, 16'h1234, 0, 0, 4'd5, 0);
        #1;
        checkOutput("ld_hazard_set", hazard,   1);
        checkOutput("ld_ready_one",  ld_ready, 1);
        exp_q.push_back({4'd5, 16'h1234});
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd5, 0);
        #1;
        checkOutput("ld_lat_n1_wr_en", wr_en,  0);
        checkOutput("ld_lat_n1_hazard", hazard, 1);
        step();
        #1;
        checkOutput("ld_lat_n2_wr_en", wr_en,   1);
        checkOutput("ld_lat_n2_dst",   wr_dst,  5);
        checkOutput("ld_lat_n2_data",  wr_data, 16'h1234);
        checkOutput("ld_hazard_clr",   hazard,  0);
        step();
        #1;
        checkOutput("ld_hazard_stays_clr", hazard, 0);
        checkOutput("ld_wr_en_off",        wr_en,  0);

        // Queue full and starvation with ALU held busy
        for (int i = 0; i < 11; i++) begin
            logic              lv;
            logic [ADDR_W-1:0] ldd;
            logic [DATA_W-1:0] ldx;
            lv  = (i <= 6);
            ldd = (i == 0) ? 4'd8 : (i == 1) ? 4'd9 : 4'd10;
            ldx = (i == 0) ? 16'h0801 : (i == 1) ? 16'h0902 : 16'h0A03;
            applyStimulus(1, 4'(i), 16'hA000 + 16'(i), lv, ldd, ldx, 0, 0, 0, 0);
            #1;
            checkOutput($sformatf("starve_alu_rdy_c%0d", i), alu_ready, exp_alu_rdy[i]);
            checkOutput($sformatf("full_ld_rdy_c%0d", i),    ld_ready,  exp_ld_rdy[i]);
            if (i == 5)       exp_q.push_back({4'd8, 16'h0801});
            else if (i == 10) exp_q.push_back({4'd9, 16'h0902});
            else              exp_q.push_back({4'(i), 16'hA000 + 16'(i)});
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back({4'd10, 16'h0A03});
        step(); step();
        #1;
        checkOutput("drain_ld_rdy", ld_ready, 1);
        checkOutput("drain_wr_en",  wr_en,    0);

        // Collision: re-issue of reg 7 in the cycle its load pops keeps it busy
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd7, 4'd7, 0);
        step();
        applyStimulus(0, 0, 0, 1, 4'd7, 16'h7777, 0, 0, 4'd7, 0);
        #1;
        checkOutput("coll_hazard_pre", hazard, 1);
        exp_q.push_back({4'd7, 16'h7777});
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd7, 4'd7, 0);
        step();
        applyStimulus(1, 4'd7, 16'h0A17, 0, 0, 0, 0, 0, 0, 4'd7);
        #1;
        checkOutput("coll_wr_en",     wr_en,  1);
        checkOutput("coll_wr_dst",    wr_dst, 7);
        checkOutput("coll_set_wins",  hazard, 1);
        exp_q.push_back({4'd7, 16'h0A17});
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd7);
        #1;
        checkOutput("alu_wr_keeps_busy", hazard, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd6);
        #1;
        checkOutput("other_reg_not_busy", hazard, 0);
        step();

        // Reset with two queued loads discards them and their busy bits
        applyStimulus(1, 4'd2, 16'h2222, 1, 4'd12, 16'hC00C, 1, 4'd12, 0, 0);
        #1;
        checkOutput("rq_alu_rdy", alu_ready, 1);
        checkOutput("rq_ld_rdy0", ld_ready,  1);
        exp_q.push_back({4'd2, 16'h2222});
        step();
        applyStimulus(1, 4'd2, 16'h2223, 1, 4'd13, 16'hD00D, 0, 0, 4'd12, 0);
        #1;
        checkOutput("rq_hazard",  hazard,   1);
        checkOutput("rq_ld_rdy1", ld_ready, 1);
        exp_q.push_back({4'd2, 16'h2223});
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd12, 4'd13);
        rst = 1'b1;
        #1;
        checkOutput("rq_full_before_rst", ld_ready, 0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("rst_wr_en",  wr_en,    0);
        checkOutput("rst_hazard", hazard,   0);
        checkOutput("rst_ld_rdy", ld_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("rst_no_write", wr_en, 0);
        end

        step();
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/scalar_wb_sequencer.md
Name: scalar_wb_sequencer

Overview:
- Write-side front end for the 16-entry scalar register file.
- Merges two result producers into the register file's single write port (wr_en / wr_dst / wr_data):
  - single-cycle ALU results;
  - load-return data from the memory stage.
- Keeps a busy scoreboard of registers with outstanding loads so the issue stage can detect read-after-load hazards on its two read addresses.
- Sits between the execute/memory stages and the scalar register file.

Parameters:
- DATA_W, 16, width of write data.
- ADDR_W, 4, register address width.
- NREG, 16, number of scalar registers (2**ADDR_W).
- LQ_DEPTH, 2, load-return queue depth (entries).
- STARVE_MAX, 4, max consecutive cycles a non-empty load queue may lose arbitration to the ALU.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  ALU result accepted this cycle; combinational.
- alu_dst  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- ld_valid  in  1  load return data present.
- ld_ready  out  1  load queue can accept; combinational from registered count.
- ld_dst  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load return data.
- issue_en  in  1  a load is being issued this cycle.
- issue_dst  in  ADDR_W  destination register of the issued load.
- rd_addr_1  in  ADDR_W  issue-stage read address 1.
- rd_addr_2  in  ADDR_W  issue-stage read address 2.
- hazard  out  1  busy[rd_addr_1] | busy[rd_addr_2]; combinational.
- wr_en  out  1  register file write enable; registered.
- wr_dst  out  ADDR_W  register file write address; registered.
- wr_data  out  DATA_W  register file write data; registered.

Behaviour:
- Reset (synchronous):
  - wr_en=0, wr_dst=0, wr_data=0.
  - Load queue emptied (count=0, read and write pointers=0).
  - busy[] all 0; starve counter=0.
  - Consequently ld_ready=1 and hazard=0 after reset.
  - Reset mid-operation discards all queued loads and pending busy bits; no write occurs in the cycle after reset.
- Load queue:
  - Circular FIFO of {dst, data}, LQ_DEPTH entries; pointers wrap modulo LQ_DEPTH.
  - ld_ready = (count < LQ_DEPTH).
  - Push when ld_valid & ld_ready.
  - Pop only entries present at the start of the cycle; no same-cycle bypass.
  - Push and pop in the same cycle leave count unchanged.
- Arbitration (evaluated each cycle):
  - force_ld = (starve == STARVE_MAX) & (count != 0).
  - alu_ready = !force_ld.
  - ALU wins if alu_valid & alu_ready. The next cycle has wr_en=1, wr_dst=alu_dst, wr_data=alu_data.
  - Otherwise, if count != 0: pop the head. The next cycle has wr_en=1 with the head's dst and data, marked as a load write.
  - Otherwise: wr_en=0 next cycle; wr_dst and wr_data hold their previous values.
- Starve counter:
  - Increments when the ALU wins while count != 0.
  - Clears on any load pop, and whenever count == 0.
  - Saturates at STARVE_MAX.
- Latency:
  - ALU result accepted in cycle N: write visible at N+1.
  - Load accepted in cycle N with no contention: popped at N+1, write visible at N+2.
- Scoreboard:
  - issue_en sets busy[issue_dst] at the next edge.
  - A load pop clears busy[dst of popped entry] at the same edge the write is registered.
  - Simultaneous set and clear of the same register: set wins (the new load is outstanding).
  - ALU writes never modify busy.
  - WAW against a pending load is prevented by the issue stage via hazard on dst; this block does not reorder.
- Width rules:
  - Data passes through unmodified at DATA_W bits.
  - Addresses are ADDR_W bits; all NREG registers, including register 0, are writable.
- Never more than one write per cycle; no write is lost or duplicated.

Test Plan:
- Reset then idle:
  - After rst high then low, expect wr_en=0, ld_ready=1, hazard=0.
  - With no valids for 5 cycles, wr_en stays 0.
- ALU only:
  - alu_valid=1, alu_dst=3, alu_data=16'hBEEF in cycle N.
  - Expect wr_en=1, wr_dst=3, wr_data=16'hBEEF at N+1, and wr_en=0 at N+2.
- Load with scoreboard:
  - issue_en=1, issue_dst=5. Next cycle, rd_addr_1=5 -> hazard=1.
  - ld_valid=1, ld_dst=5, ld_data=16'h1234 at cycle N.
  - Expect the write at N+2; from N+2 onward hazard=0 with rd_addr_1=5.
- Queue full:
  - alu_valid held 1 while 3 loads are presented back-to-back.
  - Expect ld_ready=0 after 2 accepts; the third load waits.
- Starvation:
  - Continue alu_valid=1 with a non-empty queue.
  - After 4 ALU wins, expect alu_ready=0 for one cycle and the queue head written.
  - Then the ALU resumes and the counter restarts.
- Collisions and reset:
  - issue_en for register 7 in the same cycle its pending load pops -> busy[7]=1 afterwards.
  - rst asserted with 2 queued loads -> no writes occur, hazard=0, ld_ready=1.
